// File: rtl/fp_cmp_minmax_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_cmp_minmax_pipe_if : request/response bus of the FP compare unit   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface fp_cmp_minmax_pipe_if #(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52,
   parameter int TAG_W = 5
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_result;
   logic             out_nv;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_a, in_b, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_nv, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_nv, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/fp_cmp_minmax_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_cmp_minmax_pipe : 2-stage IEEE 754 compare / FMIN / FMAX unit      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_cmp_minmax_pipe #(
   parameter int EXP_W = 11,
   parameter int MAN_W = 52,
   parameter int TAG_W = 5
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   fp_cmp_minmax_pipe_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [2:0] OP_FLE  = 3'b000;
   localparam logic [2:0] OP_FEQ  = 3'b010;
   localparam logic [2:0] OP_FLT  = 3'b011;
   localparam logic [2:0] OP_FMIN = 3'b100;
   localparam logic [2:0] OP_FMAX = 3'b101;

   localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // operand classification on the incoming bus
   logic a_nan, b_nan, a_snan, b_snan, a_qnan, b_qnan, a_zero, b_zero;
   logic mag_lt, mag_eq;

   always_comb begin
      a_nan  = (&bus.in_a[W-2:MAN_W]) & (|bus.in_a[MAN_W-1:0]);
      b_nan  = (&bus.in_b[W-2:MAN_W]) & (|bus.in_b[MAN_W-1:0]);
      a_snan = a_nan & ~bus.in_a[MAN_W-1];
      b_snan = b_nan & ~bus.in_b[MAN_W-1];
      a_qnan = a_nan &  bus.in_a[MAN_W-1];
      b_qnan = b_nan &  bus.in_b[MAN_W-1];
      a_zero = ~|bus.in_a[W-2:0];
      b_zero = ~|bus.in_b[W-2:0];
      mag_lt = bus.in_a[W-2:0] <  bus.in_b[W-2:0];
      mag_eq = bus.in_a[W-2:0] == bus.in_b[W-2:0];
   end

   logic             s1_valid, s2_valid;
   logic [W-1:0]     s1_a, s1_b;
   logic [2:0]       s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_a_snan, s1_b_snan, s1_a_qnan, s1_b_qnan, s1_a_zero, s1_b_zero;
   logic             s1_lt, s1_eq;
   logic [W-1:0]     s2_result;
   logic             s2_nv;
   logic [TAG_W-1:0] s2_tag;
   logic             s1_adv, s2_adv;

   assign s2_adv       = ~s2_valid | bus.out_ready;
   assign s1_adv       = ~s1_valid | s2_adv;
   assign bus.in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= '0;
         s1_tag    <= '0;
         s1_a_snan <= 1'b0;
         s1_b_snan <= 1'b0;
         s1_a_qnan <= 1'b0;
         s1_b_qnan <= 1'b0;
         s1_a_zero <= 1'b0;
         s1_b_zero <= 1'b0;
         s1_lt     <= 1'b0;
         s1_eq     <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_a      <= bus.in_a;
            s1_b      <= bus.in_b;
            s1_op     <= bus.in_op;
            s1_tag    <= bus.in_tag;
            s1_a_snan <= a_snan;
            s1_b_snan <= b_snan;
            s1_a_qnan <= a_qnan;
            s1_b_qnan <= b_qnan;
            s1_a_zero <= a_zero;
            s1_b_zero <= b_zero;
            s1_lt     <= mag_lt;
            s1_eq     <= mag_eq;
         end
      end
   end

   // stage-2 result formation from the registered decode
   logic             s1_a_nan, s1_b_nan, any_nan, any_snan, both_zero, sign_diff;
   logic             lt_same, lt_ord, lt_mm, eq_ord;
   logic [W-1:0]     res_d;
   logic             nv_d;

   always_comb begin
      s1_a_nan  = s1_a_snan | s1_a_qnan;
      s1_b_nan  = s1_b_snan | s1_b_qnan;
      any_nan   = s1_a_nan | s1_b_nan;
      any_snan  = s1_a_snan | s1_b_snan;
      both_zero = s1_a_zero & s1_b_zero;
      sign_diff = s1_a[W-1] ^ s1_b[W-1];
      lt_same   = s1_a[W-1] ? (~s1_lt & ~s1_eq) : s1_lt;
      lt_ord    = sign_diff ? (s1_a[W-1] & ~both_zero) : lt_same;
      // min/max orders -0 below +0, so a sign difference alone decides
      lt_mm     = sign_diff ? s1_a[W-1] : lt_same;
      eq_ord    = (~sign_diff & s1_eq) | both_zero;
      res_d     = '0;
      nv_d      = 1'b0;
      case (s1_op)
         OP_FEQ: begin
            res_d = {{(W-1){1'b0}}, ~any_nan & eq_ord};
            nv_d  = any_snan;
         end
         OP_FLT: begin
            res_d = {{(W-1){1'b0}}, ~any_nan & lt_ord};
            nv_d  = any_nan;
         end
         OP_FLE: begin
            res_d = {{(W-1){1'b0}}, ~any_nan & (lt_ord | eq_ord)};
            nv_d  = any_nan;
         end
         OP_FMIN, OP_FMAX: begin
            nv_d = any_snan;
            if (s1_a_nan && s1_b_nan)
               res_d = CANON_NAN;
            else if (s1_a_nan)
               res_d = s1_b;
            else if (s1_b_nan)
               res_d = s1_a;
            else if (s1_op == OP_FMIN)
               res_d = lt_mm ? s1_a : s1_b;
            else
               res_d = lt_mm ? s1_b : s1_a;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_nv     <= 1'b0;
         s2_tag    <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= res_d;
            s2_nv     <= nv_d;
            s2_tag    <= s1_tag;
         end
      end
   end

   assign bus.out_valid  = s2_valid;
   assign bus.out_result = s2_result;
   assign bus.out_nv     = s2_nv;
   assign bus.out_tag    = s2_tag;
endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_minmax_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_cmp_minmax_pipe : directed bench, double and single instances   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fp_cmp_minmax_pipe;
   localparam logic [2:0] OP_FLE  = 3'b000;
   localparam logic [2:0] OP_FEQ  = 3'b010;
   localparam logic [2:0] OP_FLT  = 3'b011;
   localparam logic [2:0] OP_FMIN = 3'b100;
   localparam logic [2:0] OP_FMAX = 3'b101;

   localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] D_TWO  = 64'h4000000000000000;
   localparam logic [63:0] D_M1   = 64'hBFF0000000000000;
   localparam logic [63:0] D_M2   = 64'hC000000000000000;
   localparam logic [63:0] D_PZ   = 64'h0000000000000000;
   localparam logic [63:0] D_NZ   = 64'h8000000000000000;
   localparam logic [63:0] D_QNAN = 64'h7FF8000000000000;
   localparam logic [63:0] D_SNAN = 64'h7FF0000000000001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fp_cmp_minmax_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) dbus ();
   fp_cmp_minmax_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(5)) sbus ();

   fp_cmp_minmax_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dbus.slave)
   );

   fp_cmp_minmax_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) u_sp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sbus.slave)
   );

   // issue one op on an idle pipe and wait for its result
   task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, output logic [63:0] res, output logic nv,
                         output logic [4:0] tg, output int lat);
      dbus.in_valid  = 1'b1;
      dbus.in_op     = op;
      dbus.in_a      = a;
      dbus.in_b      = b;
      dbus.in_tag    = tag;
      dbus.out_ready = 1'b1;
      @(posedge clk); #1;
      dbus.in_valid = 1'b0;
      lat = 1;
      while (!dbus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (dbus.out_valid) begin
         res = dbus.out_result;
         nv  = dbus.out_nv;
         tg  = dbus.out_tag;
      end else begin
         res = 'x;
         nv  = 1'bx;
         tg  = 'x;
         lat = 99;
      end
   endtask

   task automatic run_op_sp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output logic nv);
      int lat;
      sbus.in_valid  = 1'b1;
      sbus.in_op     = op;
      sbus.in_a      = a;
      sbus.in_b      = b;
      sbus.in_tag    = 5'd3;
      sbus.out_ready = 1'b1;
      @(posedge clk); #1;
      sbus.in_valid = 1'b0;
      lat = 1;
      while (!sbus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sbus.out_valid) begin
         res = sbus.out_result;
         nv  = sbus.out_nv;
      end else begin
         res = 'x;
         nv  = 1'bx;
      end
   endtask

   task automatic test_reset;
      logic [63:0] r; logic nv; logic [4:0] tg; int lat;
      rst_n         = 1'b0;
      dbus.in_valid = 1'b1;
      dbus.in_a     = D_ONE;
      dbus.in_b     = D_TWO;
      dbus.in_op    = OP_FLT;
      dbus.in_tag   = 5'd31;
      dbus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (dbus.out_valid !== 1'b0 || dbus.in_ready !== 1'b1 || dbus.out_result !== 64'd0 ||
             dbus.out_nv !== 1'b0 || dbus.out_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b res=%h nv=%b tag=%0d, required 0 1 0 0 0",
                     dbus.out_valid, dbus.in_ready, dbus.out_result, dbus.out_nv, dbus.out_tag);
         end
      end
      dbus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(OP_FLT, D_ONE, D_TWO, 5'd7, r, nv, tg, lat);
      n_checks++;
      if (lat !== 2 || r !== 64'd1 || nv !== 1'b0 || tg !== 5'd7) begin
         n_fail++;
         $display("FAIL first_flt: lat=%0d res=%h nv=%b tag=%0d, required 2 1 0 7", lat, r, nv, tg);
      end
   endtask

   task automatic test_compare;
      logic [63:0] r; logic nv; logic [4:0] tg; int lat;
      run_op(OP_FEQ, D_NZ, D_PZ, 5'd1, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd1 || nv !== 1'b0) begin
         n_fail++; $display("FAIL feq_zeros: res=%h nv=%b, required 1 0", r, nv);
      end
      run_op(OP_FLE, D_M2, D_M1, 5'd2, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd1 || nv !== 1'b0) begin
         n_fail++; $display("FAIL fle_neg: res=%h nv=%b, required 1 0", r, nv);
      end
      run_op(OP_FLT, D_M1, D_M2, 5'd3, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0 || nv !== 1'b0) begin
         n_fail++; $display("FAIL flt_neg_swapped: res=%h nv=%b, required 0 0", r, nv);
      end
      run_op(OP_FLT, D_TWO, D_TWO, 5'd4, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0) begin
         n_fail++; $display("FAIL flt_equal: res=%h, required 0", r);
      end
      run_op(OP_FLE, D_PZ, D_NZ, 5'd5, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd1) begin
         n_fail++; $display("FAIL fle_zeros: res=%h, required 1", r);
      end
      run_op(OP_FLT, D_NZ, D_PZ, 5'd6, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0) begin
         n_fail++; $display("FAIL flt_zeros: res=%h, required 0", r);
      end
      run_op(3'b001, D_SNAN, D_ONE, 5'd9, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0 || nv !== 1'b0 || tg !== 5'd9) begin
         n_fail++; $display("FAIL reserved_op: res=%h nv=%b tag=%0d, required 0 0 9", r, nv, tg);
      end
   endtask

   task automatic test_nan;
      logic [63:0] r; logic nv; logic [4:0] tg; int lat;
      run_op(OP_FEQ, D_QNAN, D_ONE, 5'd10, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0 || nv !== 1'b0) begin
         n_fail++; $display("FAIL feq_qnan: res=%h nv=%b, required 0 0", r, nv);
      end
      run_op(OP_FEQ, D_SNAN, D_ONE, 5'd11, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0 || nv !== 1'b1) begin
         n_fail++; $display("FAIL feq_snan: res=%h nv=%b, required 0 1", r, nv);
      end
      run_op(OP_FLT, D_QNAN, D_ONE, 5'd12, r, nv, tg, lat);
      n_checks++;
      if (r !== 64'd0 || nv !== 1'b1) begin
         n_fail++; $display("FAIL flt_qnan: res=%h nv=%b, required 0 1", r, nv);
      end
   endtask

   task automatic test_minmax;
      logic [63:0] r; logic nv; logic [4:0] tg; int lat;
      run_op(OP_FMIN, D_PZ, D_NZ, 5'd13, r, nv, tg, lat);
      n_checks++;
      if (r !== D_NZ || nv !== 1'b0) begin
         n_fail++; $display("FAIL fmin_zeros: res=%h nv=%b, required %h 0", r, nv, D_NZ);
      end
      run_op(OP_FMAX, D_PZ, D_NZ, 5'd14, r, nv, tg, lat);
      n_checks++;
      if (r !== D_PZ || nv !== 1'b0) begin
         n_fail++; $display("FAIL fmax_zeros: res=%h nv=%b, required %h 0", r, nv, D_PZ);
      end
      run_op(OP_FMAX, D_QNAN, D_TWO, 5'd15, r, nv, tg, lat);
      n_checks++;
      if (r !== D_TWO || nv !== 1'b0) begin
         n_fail++; $display("FAIL fmax_qnan: res=%h nv=%b, required %h 0", r, nv, D_TWO);
      end
      run_op(OP_FMIN, D_SNAN, D_QNAN, 5'd16, r, nv, tg, lat);
      n_checks++;
      if (r !== D_QNAN || nv !== 1'b1) begin
         n_fail++; $display("FAIL fmin_both_nan: res=%h nv=%b, required %h 1", r, nv, D_QNAN);
      end
      run_op(OP_FMIN, D_ONE, D_M2, 5'd17, r, nv, tg, lat);
      n_checks++;
      if (r !== D_M2) begin
         n_fail++; $display("FAIL fmin_mixed: res=%h, required %h", r, D_M2);
      end
      run_op(OP_FMAX, D_M1, D_M2, 5'd18, r, nv, tg, lat);
      n_checks++;
      if (r !== D_M1) begin
         n_fail++; $display("FAIL fmax_neg: res=%h, required %h", r, D_M1);
      end
   endtask

   task automatic test_back_to_back;
      int idx, got, stall;
      bit seen, saw_block, hold, acc;
      logic [63:0] h_res, exp_r;
      logic [4:0]  h_tag;
      idx = 0; got = 0; stall = 0;
      seen = 0; saw_block = 0; hold = 0; acc = 0;
      h_res = '0; h_tag = '0;
      @(posedge clk); #1;
      dbus.in_op = OP_FMAX;
      dbus.in_b  = D_PZ;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (dbus.out_valid && !seen) begin
            seen  = 1;
            stall = 4;
         end
         if (stall > 0) begin
            dbus.out_ready = 1'b0;
            stall--;
         end else begin
            dbus.out_ready = 1'b1;
         end
         dbus.in_valid = (idx < 6);
         dbus.in_a     = D_ONE + 64'(idx);
         dbus.in_tag   = idx[4:0];
         @(negedge clk);
         if (hold) begin
            n_checks++;
            if (dbus.out_valid !== 1'b1 || dbus.out_result !== h_res || dbus.out_tag !== h_tag) begin
               n_fail++;
               $display("FAIL stall_stable: valid=%b res=%h tag=%0d, required 1 %h %0d",
                        dbus.out_valid, dbus.out_result, dbus.out_tag, h_res, h_tag);
            end
         end
         hold  = dbus.out_valid && !dbus.out_ready;
         h_res = dbus.out_result;
         h_tag = dbus.out_tag;
         if (dbus.in_valid && !dbus.in_ready) saw_block = 1;
         if (dbus.out_valid && dbus.out_ready) begin
            exp_r = D_ONE + 64'(got);
            n_checks++;
            if (dbus.out_tag !== got[4:0] || dbus.out_result !== exp_r) begin
               n_fail++;
               $display("FAIL b2b_result: tag=%0d res=%h, required %0d %h",
                        dbus.out_tag, dbus.out_result, got, exp_r);
            end
            got++;
         end
         acc = dbus.in_valid && dbus.in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      n_checks++;
      if (got !== 6 || idx !== 6) begin
         n_fail++; $display("FAIL b2b_count: delivered=%0d issued=%0d, required 6 6", got, idx);
      end
      n_checks++;
      if (saw_block !== 1'b1) begin
         n_fail++; $display("FAIL b2b_in_ready: in_ready low seen=%b, required 1", saw_block);
      end
   endtask

   task automatic test_reset_midstream;
      logic [63:0] r; logic nv; logic [4:0] tg; int lat;
      bit stale;
      stale = 0;
      dbus.out_ready = 1'b1;
      dbus.in_valid  = 1'b1;
      dbus.in_op     = OP_FLT;
      dbus.in_a      = D_ONE;
      dbus.in_b      = D_TWO;
      dbus.in_tag    = 5'd21;
      @(posedge clk); #1;
      dbus.in_tag    = 5'd22;
      @(posedge clk); #1;
      dbus.in_valid  = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dbus.out_valid !== 1'b0 || dbus.out_result !== 64'd0 || dbus.out_tag !== 5'd0) begin
         n_fail++;
         $display("FAIL midreset_drop: valid=%b res=%h tag=%0d, required 0 0 0",
                  dbus.out_valid, dbus.out_result, dbus.out_tag);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dbus.out_valid) stale = 1;
      end
      n_checks++;
      if (stale !== 1'b0) begin
         n_fail++; $display("FAIL midreset_stale: stale result seen=%b, required 0", stale);
      end
      @(posedge clk); #1;
      run_op(OP_FLT, D_ONE, D_TWO, 5'd23, r, nv, tg, lat);
      n_checks++;
      if (lat !== 2 || r !== 64'd1 || tg !== 5'd23) begin
         n_fail++;
         $display("FAIL midreset_recover: lat=%0d res=%h tag=%0d, required 2 1 23", lat, r, tg);
      end
   endtask

   task automatic test_single;
      logic [31:0] r; logic nv;
      run_op_sp(OP_FLT, 32'h3F800000, 32'h40000000, r, nv);
      n_checks++;
      if (r !== 32'd1 || nv !== 1'b0) begin
         n_fail++; $display("FAIL sp_flt: res=%h nv=%b, required 1 0", r, nv);
      end
      run_op_sp(OP_FMIN, 32'h7F800001, 32'h7FC00000, r, nv);
      n_checks++;
      if (r !== 32'h7FC00000 || nv !== 1'b1) begin
         n_fail++; $display("FAIL sp_fmin_nan: res=%h nv=%b, required 7fc00000 1", r, nv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sbus.in_valid  = 1'b0;
      sbus.in_a      = '0;
      sbus.in_b      = '0;
      sbus.in_op     = '0;
      sbus.in_tag    = '0;
      sbus.out_ready = 1'b1;
      test_reset();
      test_compare();
      test_nan();
      test_minmax();
      test_back_to_back();
      test_reset_midstream();
      test_single();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fp_cmp_minmax_pipe.md
Name: fp_cmp_minmax_pipe

Overview:
Parametrised, pipelined IEEE 754 compare and min/max unit for the D/F-extension ALU.
- Generalises the combinational double-precision compare to any EXP_W/MAN_W format (default double).
- Adds FMIN/FMAX, quiet vs signalling NaN semantics with an invalid (NV) flag, and a two-stage valid/ready pipeline with a tag passthrough.
- Sits between the FP operand-read stage and FP writeback.

Parameters:
EXP_W, 11, exponent width (8 gives single precision)
MAN_W, 52, stored mantissa width (23 for single)
TAG_W, 5, width of the opaque tag carried alongside each operation
(derived) W = 1+EXP_W+MAN_W, operand width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation present on inputs
in_ready  out  1  unit can accept an operation this cycle
in_a  in  W  operand A
in_b  in  W  operand B
in_op  in  3  000 FLE, 010 FEQ, 011 FLT, 100 FMIN, 101 FMAX; other codes reserved
in_tag  in  TAG_W  tag, returned unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_result  out  W  compare: {W-1 zeros, bit}; min/max: selected value
out_nv  out  1  invalid-operation exception flag
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async, rst_n=0):
  - Both stage valid bits clear, so out_valid=0 and in_ready=1.
  - out_result, out_nv and out_tag are 0.
  - Reset mid-operation discards every in-flight operation, with no partial output.
- Pipeline:
  - S1 registers the decode: sign, zero, qNaN and sNaN per operand, magnitude compare of {exp,man} (A<B, A==B), raw operands, op and tag.
  - S2 registers the final result, NV and tag.
  - Latency: exactly 2 cycles from an in_valid&&in_ready edge to out_valid when out_ready is held 1.
- Handshake:
  - s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv.
  - Throughput is 1 op per cycle.
  - When out_ready=0 and both stages are full, in_ready=0. All stage contents hold and outputs stay stable until accepted.
  - A transfer occurs only when valid and ready are both 1. Simultaneous accept on the output and enqueue on the input in the same cycle is lossless.
- Classification:
  - NaN: exp all ones and man≠0.
  - sNaN: NaN with man MSB=0. qNaN: NaN with man MSB=1.
  - Zero: exp=0 and man=0. Subnormals compare by raw bits.
- FEQ: 1 if A==B bitwise or both zero (±0 equal); 0 if either is NaN. NV=1 only if either is sNaN.
- FLT / FLE: ordered compare.
  - Signs differ: A<B iff A negative and not both zero.
  - Signs equal: magnitude compare, inverted for negative operands.
  - FLE = FLT | FEQ-equality. Any NaN gives result 0 and NV=1.
- FMIN / FMAX:
  - Both NaN: result is the canonical NaN {0, all-ones exp, 1, zeros}.
  - One NaN: result is the other operand.
  - Otherwise the smaller (FMIN) or larger (FMAX) operand, with -0 < +0: FMIN(+0,-0)=-0, FMAX(+0,-0)=+0.
  - NV=1 iff either operand is sNaN.
- Reserved op: out_result=0, out_nv=0. It still completes and returns its tag.
- The unit is purely datapath plus pipeline control. It has no other state, and ops complete in order.

Test Plan:
- Reset then in_op=011, A=0x3FF0000000000000 (1.0), B=0x4000000000000000 (2.0), out_ready=1 → out_valid 2 cycles later, out_result=1, out_nv=0, tag echoed; out_valid=0 and in_ready=1 throughout reset.
- FEQ A=0x8000000000000000, B=0x0 → result 1, nv 0. FLE A=0xC000000000000000 (-2.0), B=0xBFF0000000000000 (-1.0) → 1. FLT with operands swapped → 0.
- NaN cases:
  - FEQ A=0x7FF8000000000000 (qNaN), B=1.0 → 0, nv 0.
  - FEQ with A=0x7FF0000000000001 (sNaN) → 0, nv 1.
  - FLT with qNaN → 0, nv 1.
- Min/max cases:
  - FMIN(+0,-0) → 0x8000000000000000; FMAX → 0x0.
  - FMAX(qNaN, 2.0) → 0x4000000000000000, nv 0.
  - FMIN(sNaN, qNaN) → 0x7FF8000000000000, nv 1.
- Backpressure:
  - 6 back-to-back ops with tags 0..5; hold out_ready=0 for 4 cycles after the first result.
  - Expect in_ready=0 once both stages are full, outputs stable, and all 6 results delivered in tag order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 ops in flight → out_valid drops immediately and no stale result appears after release. Also rerun FLT 1.0<2.0 with EXP_W=8, MAN_W=23 (0x3F800000, 0x40000000) → 1.
